// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, scan state enum and board index helpers
//   Defaults: box edge, digit width and the two edit key codes.
//   cell_idx : (x,y) -> row-major cell index.
//   group_xy : scan group g (rows, then columns, then boxes) and step s -> (x,y).
package sudoku_pkg;
  localparam int         DEF_BOX       = 3;
  localparam int         DEF_DW        = 4;
  localparam logic [4:0] DEF_KEY_ENTER = 5'h1C;
  localparam logic [4:0] DEF_KEY_CLEAR = 5'h1D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  typedef struct packed {
    int x;
    int y;
  } cell_xy_t;

  function automatic int cell_idx(input int x, input int y, input int n);
    return y * n + x;
  endfunction

  function automatic cell_xy_t group_xy(input int g, input int s, input int box);
    int       n;
    int       b;
    cell_xy_t xy;
    n = box * box;
    if (g < n) begin
      xy.x = s;
      xy.y = g;
    end else if (g < 2 * n) begin
      xy.x = g - n;
      xy.y = s;
    end else begin
      b    = g - 2 * n;
      xy.x = (b % box) * box + s % box;
      xy.y = (b / box) * box + s / box;
    end
    return xy;
  endfunction
endpackage

// File: rtl/sudoku_board_engine_if.sv
// rtl/sudoku_board_engine_if.sv - load/edit/result bundle of the board engine
//   master: drives load_start/load_valid/load_digit, key_pulse/edit_x/edit_y/n.
//   slave : drives load_done, board, given, edit_ack/edit_reject,
//           check_busy/check_valid, conflict/full/solved.
interface sudoku_board_engine_if #(
  parameter int BOX = 3,
  parameter int DW  = 4
);
  localparam int N  = BOX * BOX;
  localparam int CW = $clog2(N);

  logic              load_start;
  logic              load_valid;
  logic [DW-1:0]     load_digit;
  logic              load_done;
  logic [4:0]        key_pulse;
  logic [CW-1:0]     edit_x;
  logic [CW-1:0]     edit_y;
  logic [DW-1:0]     n;
  logic [N*N*DW-1:0] board;
  logic [N*N-1:0]    given;
  logic              edit_ack;
  logic              edit_reject;
  logic              check_busy;
  logic              check_valid;
  logic              conflict;
  logic              full;
  logic              solved;

  modport master (
    output load_start, load_valid, load_digit, key_pulse, edit_x, edit_y, n,
    input  load_done, board, given, edit_ack, edit_reject,
           check_busy, check_valid, conflict, full, solved
  );

  modport slave (
    input  load_start, load_valid, load_digit, key_pulse, edit_x, edit_y, n,
    output load_done, board, given, edit_ack, edit_reject,
           check_busy, check_valid, conflict, full, solved
  );
endinterface

// File: rtl/sudoku_conflict_scan.sv
// rtl/sudoku_conflict_scan.sv - sequential row/column/box duplicate and fill scan
//   i_clk, i_rst (async, active-low), i_board (live board), i_start (board changed).
//   o_busy: change pending or scan running; o_done: results match current board;
//   o_conflict / o_full: results of the last scan that completed without a later change.
module sudoku_conflict_scan
  import sudoku_pkg::*;
#(
  parameter int BOX = DEF_BOX,
  parameter int DW  = DEF_DW
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [BOX*BOX*BOX*BOX*DW-1:0] i_board,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_conflict,
  output logic                          o_full
);
  localparam int N  = BOX * BOX;
  localparam int CW = $clog2(N);
  localparam int GW = $clog2(3 * N);

  scan_state_t   r_state;
  scan_state_t   w_next;
  logic          r_pending;
  logic [GW-1:0] r_group;
  logic [CW-1:0] r_step;
  logic [N-1:0]  r_seen;
  logic          r_acc_conf;
  logic          r_acc_full;
  logic          r_done;
  logic          r_conflict;
  logic          r_full;

  cell_xy_t      w_xy;
  int            w_cell;
  logic [DW-1:0] w_digit;
  logic [N-1:0]  w_seen_eff;
  logic [N-1:0]  w_bit;
  logic          w_last;

  always_comb begin
    w_xy       = group_xy(int'(r_group), int'(r_step), BOX);
    w_cell     = cell_idx(w_xy.x, w_xy.y, N);
    w_digit    = DW'(i_board >> (DW * w_cell));
    // Step 0 of each group starts from an empty seen mask.
    w_seen_eff = (r_step == '0) ? '0 : r_seen;
    w_bit      = (w_digit != '0) ? (N'(1) << (int'(w_digit) - 1)) : '0;
    w_last     = (int'(r_group) == 3 * N - 1) && (int'(r_step) == N - 1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pending) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pending  <= 1'b0;
      r_group    <= '0;
      r_step     <= '0;
      r_seen     <= '0;
      r_acc_conf <= 1'b0;
      r_acc_full <= 1'b1;
      r_done     <= 1'b0;
      r_conflict <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      if (i_start)                r_pending <= 1'b1;
      else if (r_state == S_IDLE) r_pending <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_group    <= '0;
          r_step     <= '0;
          r_seen     <= '0;
          r_acc_conf <= 1'b0;
          r_acc_full <= 1'b1;
        end
        S_SCAN: begin
          r_seen <= w_seen_eff | w_bit;
          if (|(w_seen_eff & w_bit)) r_acc_conf <= 1'b1;
          if (w_digit == '0)         r_acc_full <= 1'b0;
          if (int'(r_step) == N - 1) begin
            r_step  <= '0;
            r_group <= r_group + 1'b1;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end
        default: ;
      endcase

      // A change seen during the scan (pending, or arriving now) makes its result stale.
      if (i_start) begin
        r_done <= 1'b0;
      end else if (r_state == S_DONE && !r_pending) begin
        r_done     <= 1'b1;
        r_conflict <= r_acc_conf;
        r_full     <= r_acc_full;
      end
    end
  end

  assign o_busy     = r_pending | (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_conflict = r_conflict;
  assign o_full     = r_full;
endmodule

// File: rtl/sudoku_board_engine.sv
// rtl/sudoku_board_engine.sv - Sudoku board store with streamed load, keyed edits and checking
//   i_clk, i_rst (async, active-low), bus (slave side of sudoku_board_engine_if).
//   Holds board digits and the given mask, runs the puzzle loader and edit
//   checks, and feeds every accepted change to sudoku_conflict_scan.
module sudoku_board_engine
  import sudoku_pkg::*;
#(
  parameter int         BOX       = DEF_BOX,
  parameter int         DW        = DEF_DW,
  parameter logic [4:0] KEY_ENTER = DEF_KEY_ENTER,
  parameter logic [4:0] KEY_CLEAR = DEF_KEY_CLEAR
) (
  input logic                  i_clk,
  input logic                  i_rst,
  sudoku_board_engine_if.slave bus
);
  localparam int N  = BOX * BOX;
  localparam int NN = N * N;
  localparam int IW = $clog2(NN);

  logic [NN*DW-1:0] r_board;
  logic [NN-1:0]    r_given;
  logic             r_loading;
  logic [IW-1:0]    r_load_idx;
  logic             r_load_done;
  logic             r_edit_ack;
  logic             r_edit_reject;

  logic          w_is_edit_key;
  logic [DW-1:0] w_edit_digit;
  logic          w_coord_ok;
  logic [IW-1:0] w_edit_idx;
  logic          w_edit_ok;
  logic          w_ld_given;
  logic          w_load_we;
  logic          w_load_last;
  logic          w_wr_en;
  logic [IW-1:0] w_wr_idx;
  logic [DW-1:0] w_wr_digit;
  logic          w_change;
  logic          w_scan_busy;
  logic          w_scan_done;
  logic          w_scan_conflict;
  logic          w_scan_full;

  always_comb begin
    w_is_edit_key = (bus.key_pulse == KEY_ENTER) || (bus.key_pulse == KEY_CLEAR);
    w_edit_digit  = (bus.key_pulse == KEY_ENTER) ? bus.n : '0;
    w_coord_ok    = (int'(bus.edit_x) < N) && (int'(bus.edit_y) < N);
    // Index is only meaningful when the coordinates are in range.
    w_edit_idx    = IW'(cell_idx(int'(bus.edit_x), int'(bus.edit_y), N));
    w_edit_ok     = w_is_edit_key && !bus.load_start && !r_loading && w_coord_ok &&
                    !r_given[w_edit_idx] && (int'(w_edit_digit) <= N);

    w_ld_given  = (bus.load_digit != '0) && (int'(bus.load_digit) <= N);
    w_load_we   = r_loading && bus.load_valid && !bus.load_start;
    w_load_last = w_load_we && (int'(r_load_idx) == NN - 1);

    // Loader and edits are mutually exclusive, so one write port serves both.
    w_wr_en    = w_load_we || w_edit_ok;
    w_wr_idx   = w_load_we ? r_load_idx : w_edit_idx;
    w_wr_digit = w_load_we ? (w_ld_given ? bus.load_digit : '0) : w_edit_digit;
    w_change   = w_edit_ok || w_load_last;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_board       <= '0;
      r_given       <= '0;
      r_loading     <= 1'b0;
      r_load_idx    <= '0;
      r_load_done   <= 1'b0;
      r_edit_ack    <= 1'b0;
      r_edit_reject <= 1'b0;
    end else begin
      r_load_done   <= 1'b0;
      r_edit_ack    <= w_edit_ok;
      r_edit_reject <= w_is_edit_key && !w_edit_ok;
      if (bus.load_start) begin
        r_board    <= '0;
        r_given    <= '0;
        r_loading  <= 1'b1;
        r_load_idx <= '0;
      end else begin
        if (w_wr_en) begin
          for (int c = 0; c < NN; c++) begin
            if (c == int'(w_wr_idx)) begin
              r_board[DW*c +: DW] <= w_wr_digit;
              r_given[c]          <= w_load_we && w_ld_given;
            end
          end
        end
        if (w_load_we) begin
          r_load_idx <= r_load_idx + 1'b1;
          if (w_load_last) begin
            r_loading   <= 1'b0;
            r_load_done <= 1'b1;
          end
        end
      end
    end
  end

  sudoku_conflict_scan #(.BOX(BOX), .DW(DW)) u_scan (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_board    (r_board),
    .i_start    (w_change),
    .o_busy     (w_scan_busy),
    .o_done     (w_scan_done),
    .o_conflict (w_scan_conflict),
    .o_full     (w_scan_full)
  );

  assign bus.board       = r_board;
  assign bus.given       = r_given;
  assign bus.load_done   = r_load_done;
  assign bus.edit_ack    = r_edit_ack;
  assign bus.edit_reject = r_edit_reject;
  assign bus.check_busy  = w_scan_busy;
  assign bus.check_valid = w_scan_done;
  assign bus.conflict    = w_scan_conflict;
  assign bus.full        = w_scan_full;
  assign bus.solved      = w_scan_full & ~w_scan_conflict;
endmodule

// File: tb/tb_sudoku_board_engine.sv
// tb/tb_sudoku_board_engine.sv - self-checking bench for sudoku_board_engine
module tb_sudoku_board_engine;
  localparam int         N       = 9;
  localparam int         NN      = 81;
  localparam logic [4:0] K_ENTER = 5'h1C;
  localparam logic [4:0] K_CLEAR = 5'h1D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sudoku_board_engine_if bus_if ();
  sudoku_board_engine dut (.i_clk(clk), .i_rst(rst_n), .bus(bus_if));

  int tests = 0;
  int fails = 0;
  int m_board[NN];
  bit m_given[NN];

  typedef struct {
    logic [4:0] key;
    int x;
    int y;
    int nn;
    int ack;
    int rej;
  } edit_vec_t;
  edit_vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int c = 0; c < NN; c++) begin
      m_board[c] = 0;
      m_given[c] = 0;
    end
  endfunction

  // Counts each digit per row, column and box; any count above one is a conflict.
  function automatic void model_scan(output int conf, output int full);
    int cnt[16];
    conf = 0;
    full = 1;
    for (int c = 0; c < NN; c++) if (m_board[c] == 0) full = 0;
    for (int r = 0; r < N; r++) begin
      for (int d = 0; d < 16; d++) cnt[d] = 0;
      for (int c = 0; c < N; c++) cnt[m_board[r*N+c]]++;
      for (int d = 1; d < 16; d++) if (cnt[d] > 1) conf = 1;
    end
    for (int c = 0; c < N; c++) begin
      for (int d = 0; d < 16; d++) cnt[d] = 0;
      for (int r = 0; r < N; r++) cnt[m_board[r*N+c]]++;
      for (int d = 1; d < 16; d++) if (cnt[d] > 1) conf = 1;
    end
    for (int br = 0; br < 3; br++) begin
      for (int bc = 0; bc < 3; bc++) begin
        for (int d = 0; d < 16; d++) cnt[d] = 0;
        for (int r = br * 3; r < br * 3 + 3; r++)
          for (int c = bc * 3; c < bc * 3 + 3; c++) cnt[m_board[r*N+c]]++;
        for (int d = 1; d < 16; d++) if (cnt[d] > 1) conf = 1;
      end
    end
  endfunction

  function automatic void model_edit(input logic [4:0] key, input int x, input int y,
                                     input int nn, output int ack, output int rej);
    int d;
    ack = 0;
    rej = 0;
    if (key == K_ENTER || key == K_CLEAR) begin
      d = (key == K_ENTER) ? nn : 0;
      if (x < N && y < N && d <= N && !m_given[y*N+x]) begin
        m_board[y*N+x] = d;
        ack = 1;
      end else begin
        rej = 1;
      end
    end
  endfunction

  task automatic check_board(input string name);
    int mism = 0;
    for (int c = 0; c < NN; c++) begin
      if (int'(bus_if.board[4*c +: 4]) != m_board[c]) mism++;
      if (bus_if.given[c] != m_given[c]) mism++;
    end
    chk(name, mism, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " board"}, int'(|bus_if.board), 0);
    chk({tag, " given"}, int'(|bus_if.given), 0);
    chk({tag, " load_done"}, int'(bus_if.load_done), 0);
    chk({tag, " edit_ack"}, int'(bus_if.edit_ack), 0);
    chk({tag, " edit_reject"}, int'(bus_if.edit_reject), 0);
    chk({tag, " check_busy"}, int'(bus_if.check_busy), 0);
    chk({tag, " check_valid"}, int'(bus_if.check_valid), 0);
    chk({tag, " conflict"}, int'(bus_if.conflict), 0);
    chk({tag, " full"}, int'(bus_if.full), 0);
    chk({tag, " solved"}, int'(bus_if.solved), 0);
  endtask

  task automatic wait_valid(input string name, input int budget, output int cyc);
    cyc = 0;
    while (bus_if.check_valid !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({name, " check_valid within budget"}, int'(bus_if.check_valid === 1'b1), 1);
  endtask

  task automatic check_results(input string name);
    int conf, full;
    model_scan(conf, full);
    chk({name, " conflict"}, int'(bus_if.conflict), conf);
    chk({name, " full"}, int'(bus_if.full), full);
    chk({name, " solved"}, int'(bus_if.solved), int'(full == 1 && conf == 0));
  endtask

  task automatic do_edit(input logic [4:0] key, input int x, input int y, input int nn,
                         output int ack, output int rej);
    bus_if.key_pulse = key;
    bus_if.edit_x    = 4'(x);
    bus_if.edit_y    = 4'(y);
    bus_if.n         = 4'(nn);
    tick();
    ack = int'(bus_if.edit_ack);
    rej = int'(bus_if.edit_reject);
    bus_if.key_pulse = 5'd0;
  endtask

  function automatic int char_digit(input string s, input int i);
    if (s[i] == 8'h2E) return 0;
    return int'(s[i]) - 48;
  endfunction

  // Feeds the first cnt characters of s; '.' is empty, ':' and ';' are out-of-range digits.
  task automatic load_string(input string s, input int cnt);
    int d, early, last;
    early = 0;
    last  = 0;
    bus_if.load_start = 1'b1;
    tick();
    bus_if.load_start = 1'b0;
    model_clear();
    for (int i = 0; i < cnt; i++) begin
      d = char_digit(s, i);
      bus_if.load_valid = 1'b1;
      bus_if.load_digit = 4'(d);
      tick();
      if (d >= 1 && d <= N) begin
        m_board[i] = d;
        m_given[i] = 1;
      end
      if (i < NN - 1 && bus_if.load_done) early++;
      if (i == NN - 1) last = int'(bus_if.load_done);
    end
    bus_if.load_valid = 1'b0;
    if (cnt == NN) begin
      chk("load_done before last cell", early, 0);
      chk("load_done after cell 80", last, 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string puz, sol, solh;
    int ack, rej, cyc, conf, full;
    puz  = {"53..7....", "6..195...", ".98....6.", "8...6...3", "4..8.3..1",
            "7...2...6", ".6....28.", "...419..5", "....8..79"};
    sol  = {"534678912", "672195348", "198342567", "859761423", "426853791",
            "713924856", "961537284", "287419635", "345286179"};
    solh = {"53:678912", "672195348", "198342567", "859761423", "426853791",
            "713924856", "961537284", "287419635", "345286;79"};

    tbl[0]  = '{K_ENTER, 2, 0, 4, 1, 0};
    tbl[1]  = '{K_ENTER, 0, 0, 1, 0, 1};
    tbl[2]  = '{K_ENTER, 9, 0, 1, 0, 1};
    tbl[3]  = '{K_ENTER, 2, 0, 10, 0, 1};
    tbl[4]  = '{K_ENTER, 3, 9, 1, 0, 1};
    tbl[5]  = '{5'h05, 2, 0, 3, 0, 0};
    tbl[6]  = '{K_CLEAR, 1, 0, 0, 0, 1};
    tbl[7]  = '{K_CLEAR, 2, 0, 0, 1, 0};
    tbl[8]  = '{K_ENTER, 7, 7, 3, 1, 0};
    tbl[9]  = '{K_ENTER, 2, 0, 0, 1, 0};
    tbl[10] = '{K_ENTER, 15, 15, 9, 0, 1};
    tbl[11] = '{K_CLEAR, 8, 8, 0, 0, 1};

    bus_if.load_start = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_digit = '0;
    bus_if.key_pulse  = '0;
    bus_if.edit_x     = '0;
    bus_if.edit_y     = '0;
    bus_if.n          = '0;
    model_clear();

    tick();
    tick();
    check_zero("in reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_zero("after reset");

    // Standard puzzle
    load_string(puz, NN);
    chk("given popcount", $countones(bus_if.given), 30);
    check_board("puzzle board");
    chk("load check_busy", int'(bus_if.check_busy), 1);
    wait_valid("puzzle", 400, cyc);
    chk("puzzle scan latency", cyc, 245);
    check_results("puzzle");

    // Table-driven edits
    for (int i = 0; i < 12; i++) begin
      do_edit(tbl[i].key, tbl[i].x, tbl[i].y, tbl[i].nn, ack, rej);
      chk($sformatf("tbl%0d edit_ack", i), ack, tbl[i].ack);
      chk($sformatf("tbl%0d edit_reject", i), rej, tbl[i].rej);
      if (tbl[i].ack == 1) m_board[tbl[i].y*N+tbl[i].x] = (tbl[i].key == K_ENTER) ? tbl[i].nn : 0;
      check_board($sformatf("tbl%0d board", i));
    end
    wait_valid("after table", 600, cyc);
    check_results("after table");

    // Duplicate 5 in row 0, then clear it
    do_edit(K_ENTER, 2, 0, 5, ack, rej);
    chk("dup edit ack", ack, 1);
    m_board[2] = 5;
    wait_valid("dup", 600, cyc);
    chk("dup conflict", int'(bus_if.conflict), 1);
    check_results("dup");
    do_edit(K_CLEAR, 2, 0, 0, ack, rej);
    chk("clear edit ack", ack, 1);
    m_board[2] = 0;
    wait_valid("cleared", 600, cyc);
    chk("cleared conflict", int'(bus_if.conflict), 0);

    // Randomized edits against the model
    for (int i = 0; i < 40; i++) begin
      logic [4:0] key;
      int x, y, nn, eack, erej, sel;
      sel = $urandom_range(0, 3);
      key = (sel == 0 || sel == 1) ? K_ENTER : (sel == 2) ? K_CLEAR : 5'($urandom_range(0, 27));
      x   = $urandom_range(0, 10);
      y   = $urandom_range(0, 10);
      nn  = $urandom_range(0, 11);
      model_edit(key, x, y, nn, eack, erej);
      do_edit(key, x, y, nn, ack, rej);
      chk($sformatf("rand%0d edit_ack", i), ack, eack);
      chk($sformatf("rand%0d edit_reject", i), rej, erej);
      if (i % 10 == 9) begin
        wait_valid("rand", 800, cyc);
        check_results($sformatf("rand%0d", i));
        check_board($sformatf("rand%0d board", i));
      end
    end

    // Solution with hole at (2,0) and an out-of-range digit at (6,8)
    load_string(solh, NN);
    check_board("holed solution board");
    wait_valid("holed", 400, cyc);
    check_results("holed");
    do_edit(K_ENTER, 6, 8, 1, ack, rej);
    chk("fill (6,8) ack", ack, 1);
    m_board[8*N+6] = 1;
    do_edit(K_ENTER, 2, 0, 4, ack, rej);
    chk("fill (2,0) ack", ack, 1);
    m_board[2] = 4;
    wait_valid("solved", 600, cyc);
    chk("solved flag", int'(bus_if.solved), 1);
    check_results("solved");

    // Duplicate edit while a scan is running
    do_edit(K_ENTER, 2, 0, 4, ack, rej);
    chk("rescan trigger ack", ack, 1);
    for (int i = 0; i < 100; i++) tick();
    chk("mid-scan busy", int'(bus_if.check_busy), 1);
    chk("mid-scan valid", int'(bus_if.check_valid), 0);
    do_edit(K_ENTER, 2, 0, 5, ack, rej);
    chk("mid-scan dup ack", ack, 1);
    m_board[2] = 5;
    wait_valid("mid-scan", 800, cyc);
    chk("mid-scan result latency", 101 + cyc, 490);
    check_results("mid-scan");

    // Reset during a scan
    do_edit(K_ENTER, 2, 0, 4, ack, rej);
    for (int i = 0; i < 50; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset mid-scan");
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();

    // load_start wins over a same-cycle edit
    load_string(puz, NN);
    bus_if.load_start = 1'b1;
    bus_if.key_pulse  = K_ENTER;
    bus_if.edit_x     = 4'd2;
    bus_if.edit_y     = 4'd0;
    bus_if.n          = 4'd1;
    tick();
    chk("start+edit reject", int'(bus_if.edit_reject), 1);
    chk("start+edit ack", int'(bus_if.edit_ack), 0);
    bus_if.load_start = 1'b0;
    bus_if.key_pulse  = 5'd0;
    model_clear();
    check_board("start+edit board");
    do_edit(K_ENTER, 2, 0, 1, ack, rej);
    chk("edit during load reject", rej, 1);
    check_board("edit during load board");

    // Reset during a load
    load_string(puz, 40);
    check_board("partial load board");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset mid-load");
    model_clear();
    tick();
    rst_n = 1'b1;
    bus_if.load_valid = 1'b1;
    bus_if.load_digit = 4'd5;
    tick();
    tick();
    tick();
    bus_if.load_valid = 1'b0;
    check_board("load_valid ignored after reset");
    chk("no load_done after reset", int'(bus_if.load_done), 0);

    model_scan(conf, full);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
